// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the core data-port to SRAM bridge: access size encodings
// and the byte-enable table used by both the RTL and the bench.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } dsize_e;

    function automatic logic [3:0] be_table(dsize_e size, logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Core data port plus SRAM port 2, bundled as one bus. The bridge takes the slave
// view; the environment (core model and SRAM) takes the master view.
interface dmem_bridge_if #(
    parameter int unsigned AW = 12
) ();
    logic          dreq;
    logic [31:0]   daddr;
    logic          drw;
    logic [1:0]    dsize;
    logic [31:0]   dout;
    logic [31:0]   din;
    logic          mem_csn;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_di;
    logic [31:0]   mem_do;

    modport slave (
        input  dreq, daddr, drw, dsize, dout, mem_do,
        output din, mem_csn, mem_addr, mem_we, mem_be, mem_di
    );

    modport master (
        output dreq, daddr, drw, dsize, dout, mem_do,
        input  din, mem_csn, mem_addr, mem_we, mem_be, mem_di
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Extracts the addressed lane(s) from an SRAM read word and zero-extends them
// into a right-aligned value.
module dmem_lane_align
    import dmem_bridge_pkg::*;
(
    input  logic [31:0] mem_do,
    input  logic [1:0]  off,
    input  dsize_e      size,
    output logic [31:0] data
);
    logic [31:0] shifted;

    assign shifted = mem_do >> {off, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            SZ_BYTE: data = {24'h0, shifted[7:0]};
            SZ_HALF: data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end
endmodule

// File: rtl/dmem_bridge.sv
// Data-side adapter: decodes core accesses into SRAM byte enables and lane-replicated
// write data, realigns read data one cycle later, and tracks faults and access counts.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned AW = 12,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_bridge_if.slave  bus,
    input  logic          clr_fault,
    output logic          fault,
    output logic [31:0]   fault_addr,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] wr_cnt
);
    dsize_e size;
    logic   size_ok, aligned, in_range, ok, reject, rd_accept, wr_accept;

    assign size     = dsize_e'(bus.dsize);
    assign size_ok  = (size != SZ_ILL);
    assign in_range = ~|bus.daddr[31:AW+2];

    always_comb begin
        aligned = 1'b0;
        case (size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~bus.daddr[0];
            SZ_WORD: aligned = (bus.daddr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign ok        = bus.dreq & size_ok & aligned & in_range;
    assign reject    = bus.dreq & ~ok;
    assign rd_accept = ok & ~bus.drw;
    assign wr_accept = ok & bus.drw;

    // Request stage: purely combinational, the SRAM samples on the clock edge.
    assign bus.mem_csn  = ~ok;
    assign bus.mem_we   = wr_accept;
    assign bus.mem_addr = bus.daddr[AW+1:2];
    assign bus.mem_be   = ok ? be_table(size, bus.daddr[1:0]) : 4'b0000;

    always_comb begin
        bus.mem_di = bus.dout;
        case (size)
            SZ_BYTE: bus.mem_di = {4{bus.dout[7:0]}};
            SZ_HALF: bus.mem_di = {2{bus.dout[15:0]}};
            default: bus.mem_di = bus.dout;
        endcase
    end

    // Response stage state
    logic          rd_pend_q, rd_pend_d;
    logic [1:0]    off_q, off_d;
    dsize_e        size_q, size_d;
    logic [31:0]   hold_q, hold_d;
    logic          fault_q, fault_d;
    logic [31:0]   fault_addr_q, fault_addr_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [31:0]   aligned_data;

    dmem_lane_align u_lane_align (
        .mem_do (bus.mem_do),
        .off    (off_q),
        .size   (size_q),
        .data   (aligned_data)
    );

    // DIN follows the SRAM only in the cycle after an accepted read, else holds.
    assign bus.din = rd_pend_q ? aligned_data : hold_q;

    always_comb begin
        rd_pend_d    = rd_accept;
        off_d        = off_q;
        size_d       = size_q;
        hold_d       = hold_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;

        if (rd_accept) begin
            off_d  = bus.daddr[1:0];
            size_d = size;
        end
        if (rd_pend_q) hold_d = aligned_data;

        if (clr_fault) begin
            fault_d      = 1'b0;
            fault_addr_d = 32'h0;
        end
        // A fault arriving with a clear wins and becomes the new first fault.
        if (reject) begin
            fault_d = 1'b1;
            if (!fault_q || clr_fault) fault_addr_d = bus.daddr;
        end

        if (rd_accept && !(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + CW'(1);
        if (wr_accept && !(&wr_cnt_q)) wr_cnt_d = wr_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q    <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= SZ_BYTE;
            hold_q       <= 32'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            rd_pend_q    <= rd_pend_d;
            off_q        <= off_d;
            size_q       <= size_d;
            hold_q       <= hold_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;
endmodule
